adc_conditioner: RTL and testbench

Downstream stage of the capacitor-discharge ADC. Watches the `capacitor` phase signal and captures the raw 32-bit discharge count once per conversion. It then clamps, offset-corrects and scales the count to a signed audio sample, and box-averages 2^AVG_LOG2 conversions. The result is a signed OUTSIZE-bit sample with a one-cycle valid strobe for the audio mixer/filter chain.

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_scale.sv | 46 ++++
 rtl/adc_conditioner.sv | 138 +++++++++++++
 tb/tb_adc_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the capacitor-discharge ADC conditioner.
package adc_pkg;

  localparam int unsigned ADC_COUNT_MAX = 4096;
  localparam int unsigned ADC_MIDPOINT  = 2048;
  localparam int unsigned OSC_HZ        = 49_152_000;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CORRECT,
    ACCUM,
    OUTPUT
  } adc_state_e;

endpackage

// File: rtl/adc_scale.sv
// Combinational clamp / offset / optional invert / gain shift / saturate of a raw count.
module adc_scale #(
  parameter int unsigned OUTSIZE    = 16,
  parameter int unsigned COUNT_MAX  = 4096,
  parameter int unsigned MIDPOINT   = 2048,
  parameter int unsigned GAIN_SHIFT = 4,
  parameter int unsigned INVERT     = 0
) (
  input  logic [$clog2(COUNT_MAX):0] raw_lo,
  input  logic                       raw_hi,
  output logic [OUTSIZE-1:0]         value_c,
  output logic                       clamp_c
);

  localparam int unsigned CW = $clog2(COUNT_MAX);
  localparam int unsigned IW = CW + 1;
  localparam int unsigned WW = (CW + 2 + GAIN_SHIFT > OUTSIZE + 1) ? (CW + 2 + GAIN_SHIFT)
                                                                    : (OUTSIZE + 1);
  localparam int SMAX_I = (1 << (OUTSIZE - 1)) - 1;
  localparam int SMIN_I = -(1 << (OUTSIZE - 1));
  localparam logic signed [WW-1:0] SMAX = WW'(SMAX_I);
  localparam logic signed [WW-1:0] SMIN = WW'(SMIN_I);

  logic [CW-1:0]        clamped;
  logic signed [WW-1:0] diff;
  logic signed [WW-1:0] scaled;

  // Wide signed intermediate so the shift can never wrap before saturation.
  always_comb begin
    clamp_c = raw_hi | (raw_lo >= IW'(COUNT_MAX));
    clamped = clamp_c ? CW'(COUNT_MAX - 1) : raw_lo[CW-1:0];
    diff    = $signed(WW'(clamped)) - $signed(WW'(MIDPOINT));
    if (INVERT != 0) begin
      diff = -diff;
    end
    scaled = diff <<< GAIN_SHIFT;
    if (scaled > SMAX) begin
      value_c = SMAX[OUTSIZE-1:0];
    end else if (scaled < SMIN) begin
      value_c = SMIN[OUTSIZE-1:0];
    end else begin
      value_c = scaled[OUTSIZE-1:0];
    end
  end

endmodule

// File: rtl/adc_conditioner.sv
// Captures one discharge count per conversion, scales it and box-averages a batch
// into a signed audio sample with a one-cycle valid strobe.
module adc_conditioner
  import adc_pkg::*;
#(
  parameter int unsigned OUTSIZE    = 16,
  parameter int unsigned COUNT_MAX  = ADC_COUNT_MAX,
  parameter int unsigned MIDPOINT   = ADC_MIDPOINT,
  parameter int unsigned GAIN_SHIFT = 4,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned INVERT     = 0
) (
  input  logic               osc,
  input  logic               reset,
  input  logic               capacitor,
  input  logic [31:0]        raw_count,
  output logic [OUTSIZE-1:0] sample,
  output logic               sample_valid,
  output logic               overrange
);

  localparam int unsigned CW    = $clog2(COUNT_MAX);
  localparam int unsigned AW    = OUTSIZE + AVG_LOG2;
  localparam int unsigned NW    = AVG_LOG2 + 1;
  localparam int unsigned BATCH = 1 << AVG_LOG2;

  adc_state_e                 state_q, state_d;
  logic                       cap_q;
  logic [CW:0]                raw_lo_q, raw_lo_d;
  logic                       raw_hi_q, raw_hi_d;
  logic signed [OUTSIZE-1:0]  corr_q, corr_d;
  logic signed [AW-1:0]       acc_q, acc_d, acc_sum;
  logic [NW-1:0]              cnt_q, cnt_d;
  logic                       batch_ovr_q, batch_ovr_d;
  logic [OUTSIZE-1:0]         sample_d;
  logic                       sample_valid_d, overrange_d;
  logic                       fall_c;
  logic [OUTSIZE-1:0]         scaled_c;
  logic                       clamp_c;

  assign fall_c = cap_q & ~capacitor;

  adc_scale #(
    .OUTSIZE    (OUTSIZE),
    .COUNT_MAX  (COUNT_MAX),
    .MIDPOINT   (MIDPOINT),
    .GAIN_SHIFT (GAIN_SHIFT),
    .INVERT     (INVERT)
  ) u_scale (
    .raw_lo  (raw_lo_q),
    .raw_hi  (raw_hi_q),
    .value_c (scaled_c),
    .clamp_c (clamp_c)
  );

  // Next-state and datapath: capture -> correct -> accumulate -> (strobe).
  always_comb begin
    state_d        = state_q;
    raw_lo_d       = raw_lo_q;
    raw_hi_d       = raw_hi_q;
    corr_d         = corr_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    batch_ovr_d    = batch_ovr_q;
    sample_d       = sample;
    sample_valid_d = 1'b0;
    overrange_d    = overrange;
    acc_sum        = acc_q + AW'(corr_q);

    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        raw_lo_d = raw_count[CW:0];
        raw_hi_d = |raw_count[31:CW+1];
        state_d  = CORRECT;
      end
      CORRECT: begin
        corr_d      = scaled_c;
        batch_ovr_d = batch_ovr_q | clamp_c;
        state_d     = ACCUM;
      end
      ACCUM: begin
        if (cnt_q == NW'(BATCH - 1)) begin
          sample_d       = OUTSIZE'(acc_sum >>> AVG_LOG2);
          sample_valid_d = 1'b1;
          overrange_d    = batch_ovr_q;
          acc_d          = '0;
          cnt_d          = '0;
          batch_ovr_d    = 1'b0;
          state_d        = OUTPUT;
        end else begin
          acc_d   = acc_sum;
          cnt_d   = cnt_q + NW'(1);
          state_d = IDLE;
        end
      end
      OUTPUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge osc) begin
    if (reset) begin
      state_q      <= IDLE;
      cap_q        <= 1'b0;
      raw_lo_q     <= '0;
      raw_hi_q     <= 1'b0;
      corr_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      batch_ovr_q  <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrange    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_q        <= capacitor;
      raw_lo_q     <= raw_lo_d;
      raw_hi_q     <= raw_hi_d;
      corr_q       <= corr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      batch_ovr_q  <= batch_ovr_d;
      sample       <= sample_d;
      sample_valid <= sample_valid_d;
      overrange    <= overrange_d;
    end
  end

endmodule

// File: tb/tb_adc_conditioner.sv
// Randomized bench for adc_conditioner: three configurations share one stimulus
// and are checked against a conversion-level model of the conditioner.
module tb_adc_conditioner;

  localparam int NDUT = 3;

  typedef struct {
    int cyc;
    int dut;
    int s;
    bit o;
  } ev_t;

  logic        osc;
  logic        reset;
  logic        capacitor;
  logic [31:0] raw_count;
  logic [15:0] smp [NDUT];
  logic        vld [NDUT];
  logic        ovr [NDUT];

  int  lg  [NDUT] = '{2, 0, 0};
  bit  inv [NDUT] = '{0, 0, 1};

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = -1;
  bit  prev_cap = 0;
  int  last_acc = -100;
  int  zero_at = -1;
  int  bsum [NDUT];
  int  bcnt [NDUT];
  bit  bovr [NDUT];
  int  exp_s [NDUT];
  bit  exp_o [NDUT];
  ev_t evq [$];

  adc_conditioner #(.AVG_LOG2(2), .INVERT(0)) u_avg (
    .osc(osc), .reset(reset), .capacitor(capacitor), .raw_count(raw_count),
    .sample(smp[0]), .sample_valid(vld[0]), .overrange(ovr[0]));

  adc_conditioner #(.AVG_LOG2(0), .INVERT(0)) u_pass (
    .osc(osc), .reset(reset), .capacitor(capacitor), .raw_count(raw_count),
    .sample(smp[1]), .sample_valid(vld[1]), .overrange(ovr[1]));

  adc_conditioner #(.AVG_LOG2(0), .INVERT(1)) u_inv (
    .osc(osc), .reset(reset), .capacitor(capacitor), .raw_count(raw_count),
    .sample(smp[2]), .sample_valid(vld[2]), .overrange(ovr[2]));

  initial osc = 1'b0;
  always #5 osc = ~osc;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ideal transfer: clamp to 0..4095, remove 2048, optional negate, x16, saturate.
  function automatic int model_scale(input logic [31:0] raw, input bit neg, output bit clip);
    int c;
    int v;
    clip = (raw >= 32'd4096);
    c = clip ? 4095 : int'(raw);
    v = (c - 2048) * 16;
    if (neg) v = -v;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic convert(input logic [31:0] raw);
    bit clip;
    for (int d = 0; d < NDUT; d++) begin
      bsum[d] += model_scale(raw, inv[d], clip);
      bcnt[d]++;
      bovr[d] |= clip;
      if (bcnt[d] == (1 << lg[d])) begin
        evq.push_back('{cyc: cyc + 4, dut: d, s: bsum[d] >>> lg[d], o: bovr[d]});
        bsum[d] = 0;
        bcnt[d] = 0;
        bovr[d] = 0;
      end
    end
  endtask

  task automatic verify();
    int ev;
    if (cyc == zero_at) begin
      for (int d = 0; d < NDUT; d++) begin
        exp_s[d] = 0;
        exp_o[d] = 0;
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      ev = 0;
      foreach (evq[i]) begin
        if (evq[i].cyc == cyc && evq[i].dut == d) begin
          ev = 1;
          exp_s[d] = evq[i].s;
          exp_o[d] = evq[i].o;
        end
      end
      check($sformatf("valid d%0d c%0d", d, cyc), int'(vld[d]), ev);
      check($sformatf("sample d%0d c%0d", d, cyc), int'($signed(smp[d])), exp_s[d]);
      check($sformatf("overrange d%0d c%0d", d, cyc), int'(ovr[d]), int'(exp_o[d]));
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].cyc <= cyc) evq.delete(i);
    end
  endtask

  // One clock: check outputs of this cycle, apply inputs, advance the model.
  task automatic tick(input logic cap, input logic [31:0] raw, input logic rst);
    @(posedge osc);
    #1;
    cyc++;
    if (cyc > 0) verify();
    capacitor = cap;
    raw_count = raw;
    reset     = rst;
    if (rst) begin
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].cyc > cyc) evq.delete(i);
      end
      for (int d = 0; d < NDUT; d++) begin
        bsum[d] = 0;
        bcnt[d] = 0;
        bovr[d] = 0;
      end
      zero_at  = cyc + 1;
      prev_cap = 0;
      last_acc = -100;
    end else begin
      if (prev_cap && !cap && (cyc - last_acc >= 4)) begin
        last_acc = cyc;
        convert(raw);
      end
      prev_cap = cap;
    end
  endtask

  // One conversion; rst_at >= 0 pulses reset that many cycles into the low phase.
  task automatic conv(input logic [31:0] raw, input int hi, input int lo, input int rst_at);
    for (int i = 0; i < hi; i++) tick(1'b1, raw, 1'b0);
    for (int i = 0; i < lo; i++) tick(1'b0, raw, (i == rst_at));
  endtask

  task automatic dbl_edge(input logic [31:0] raw);
    for (int i = 0; i < 8; i++) tick(1'b1, raw, 1'b0);
    tick(1'b0, raw, 1'b0);
    tick(1'b1, raw, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, raw, 1'b0);
  endtask

  function automatic logic [31:0] rand_raw();
    case ($urandom_range(0, 5))
      0:       return 32'd4095;
      1:       return 32'd4096;
      2:       return $urandom();
      3:       return 32'd0;
      default: return 32'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    capacitor = 1'b1;
    raw_count = '0;
    reset     = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      bsum[d] = 0; bcnt[d] = 0; bovr[d] = 0; exp_s[d] = 0; exp_o[d] = 0;
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 32'd0, 1'b1);

    conv(32'd2048, 10, 10, -1);
    conv(32'd2049, 10, 10, -1);
    conv(32'd2050, 10, 10, -1);
    conv(32'd2051, 10, 10, -1);

    conv(32'd4095, 8, 8, -1);
    conv(32'd0, 8, 8, -1);
    conv(32'h0001_0000, 8, 8, -1);
    conv(32'd2048, 8, 8, -1);
    for (int i = 0; i < 4; i++) conv(32'd2048, 8, 8, -1);

    conv(32'd4000, 8, 8, -1);
    conv(32'd100, 8, 8, -1);
    tick(1'b1, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) conv(32'd2176, 8, 8, -1);

    dbl_edge(32'd3000);
    for (int i = 0; i < 3; i++) conv(32'd1000, 8, 8, -1);

    conv(32'd2500, 8, 8, 2);
    for (int i = 0; i < 4; i++) conv(32'd1500, 8, 8, -1);

    for (int n = 0; n < 60; n++) begin
      conv(rand_raw(), $urandom_range(6, 20), $urandom_range(6, 20),
           ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 5)) : -1);
    end

    for (int i = 0; i < 20000; i++) tick(1'b1, $urandom(), 1'b0);
    for (int i = 0; i < 200; i++) tick(1'b0, 32'd77, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, 32'd77, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
